// File: rtl/memory_access_if.sv
// Data-memory request/ready port between the MEM stage (master) and memory (slave).
interface memory_access_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: byte/half/word loads and stores over a request/ready port,
// stalling upstream while an access is outstanding; drives the MEM/WB register.

// One byte lane of the store path: enable and replicated data for lane LANE.
module memory_access_lane #(parameter int LANE = 0) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    be    = 1'b1;
    wbyte = sdata[8*LANE +: 8];
    case (size)
      2'b00: begin
        be    = (addr_lo == L);
        wbyte = sdata[7:0];
      end
      2'b01: begin
        be    = (addr_lo[1] == L[1]);
        wbyte = L[0] ? sdata[15:8] : sdata[7:0];
      end
      default: ;
    endcase
  end
endmodule

module memory_access #(parameter int ADDR_W = 32) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  inWB,
  input  logic [2:0]  inMEM,
  input  logic [2:0]  inSize,
  input  logic [31:0] inALUResult,
  input  logic [31:0] inRegB,
  input  logic [4:0]  inRegF_wreg,
  input  logic        stop_debug,
  memory_access_if.master dm,
  output logic        outStall,
  output logic [1:0]  outWB,
  output logic [31:0] outReadData,
  output logic [31:0] outALUResult,
  output logic [4:0]  outRegF_wreg,
  output logic        outMisaligned
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic       mem_read, mem_write, mem_op, is_store;
  logic [1:0] size, addr_lo;
  logic       zext, misaligned, aligned_op, done;
  logic       unused_branch;

  assign unused_branch = inMEM[2];
  assign mem_read      = inMEM[1];
  assign mem_write     = inMEM[0];
  assign mem_op        = mem_read | mem_write;
  assign is_store      = mem_write & ~mem_read;
  assign size          = inSize[1:0];
  assign zext          = inSize[2];
  assign addr_lo       = inALUResult[1:0];

  always_comb begin
    misaligned = 1'b0;
    if (mem_op) begin
      case (size)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = addr_lo[0];
        default: misaligned = (addr_lo != 2'b00);
      endcase
    end
  end

  assign aligned_op = mem_op & ~misaligned;
  // A debug freeze hides dm.ready so the completion is not consumed.
  assign done       = (state == BUSY) & dm.ready & ~stop_debug;
  assign outStall   = aligned_op & ~done;

  logic [NUM_LANES-1:0][VEC_W-1:0] wdata_lane;
  logic [NUM_LANES-1:0]            be_lane;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    memory_access_lane #(.LANE(g)) u_lane (
      .size    (size),
      .addr_lo (addr_lo),
      .sdata   (inRegB),
      .be      (be_lane[g]),
      .wbyte   (wdata_lane[g])
    );
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ld_byte = dm.rdata[{addr_lo, 3'b000} +: 8];
  assign ld_half = addr_lo[1] ? dm.rdata[31:16] : dm.rdata[15:0];

  always_comb begin
    case (size)
      2'b00:   ld_data = zext ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = zext ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dm.rdata;
    endcase
  end

  logic [31:0] addr_al;
  assign addr_al = {inALUResult[31:2], 2'b00};

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      dm.req        <= 1'b0;
      dm.we         <= 1'b0;
      dm.addr       <= '0;
      dm.wdata      <= '0;
      dm.be         <= '0;
      outWB         <= 2'b00;
      outReadData   <= '0;
      outALUResult  <= '0;
      outRegF_wreg  <= '0;
      outMisaligned <= 1'b0;
    end else if (!stop_debug) begin
      case (state)
        IDLE: begin
          if (aligned_op) begin
            dm.req        <= 1'b1;
            dm.we         <= is_store;
            dm.addr       <= ADDR_W'(addr_al);
            dm.wdata      <= wdata_lane;
            dm.be         <= be_lane;
            outWB         <= 2'b00;
            outMisaligned <= 1'b0;
            state         <= BUSY;
          end else begin
            // Misaligned ops retire here as a bubble with an error pulse.
            outWB         <= misaligned ? 2'b00 : inWB;
            outReadData   <= '0;
            outALUResult  <= inALUResult;
            outRegF_wreg  <= inRegF_wreg;
            outMisaligned <= misaligned;
          end
        end
        BUSY: begin
          outMisaligned <= 1'b0;
          if (dm.ready) begin
            dm.req       <= 1'b0;
            outWB        <= inWB;
            outReadData  <= is_store ? 32'h0 : ld_data;
            outALUResult <= inALUResult;
            outRegF_wreg <= inRegF_wreg;
            state        <= IDLE;
          end else begin
            outWB <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: one task per scenario, inline checks.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  inWB = '0;
  logic [2:0]  inMEM = '0;
  logic [2:0]  inSize = '0;
  logic [31:0] inALUResult = '0;
  logic [31:0] inRegB = '0;
  logic [4:0]  inRegF_wreg = '0;
  logic        stop_debug = 1'b0;
  logic        outStall;
  logic [1:0]  outWB;
  logic [31:0] outReadData;
  logic [31:0] outALUResult;
  logic [4:0]  outRegF_wreg;
  logic        outMisaligned;

  int n_tests = 0;
  int n_fail  = 0;

  memory_access_if #(.ADDR_W(32)) dmi ();

  memory_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .inWB(inWB), .inMEM(inMEM), .inSize(inSize),
    .inALUResult(inALUResult), .inRegB(inRegB), .inRegF_wreg(inRegF_wreg),
    .stop_debug(stop_debug), .dm(dmi.master), .outStall(outStall), .outWB(outWB),
    .outReadData(outReadData), .outALUResult(outALUResult),
    .outRegF_wreg(outRegF_wreg), .outMisaligned(outMisaligned)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    inMEM = 3'b000; inWB = 2'b00; inSize = 3'b000;
  endtask

  task automatic test_reset;
    dmi.ready = 1'b0; dmi.rdata = '0;
    #2;
    n_tests++; if (dmi.req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0b exp=0", dmi.req); end
    n_tests++; if (outWB !== 2'b00 || outReadData !== 32'h0 || outALUResult !== 32'h0) begin n_fail++; $display("FAIL rst_outs got wb=%b rd=%h alu=%h exp 0", outWB, outReadData, outALUResult); end
    n_tests++; if (dmi.addr !== 32'h0 || dmi.be !== 4'h0 || outMisaligned !== 1'b0 || outStall !== 1'b0) begin n_fail++; $display("FAIL rst_misc got addr=%h be=%b mis=%b stall=%b exp 0", dmi.addr, dmi.be, outMisaligned, outStall); end
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_passthru;
    inWB = 2'b10; inMEM = 3'b000; inALUResult = 32'h1234; inRegF_wreg = 5'd5;
    #1;
    n_tests++; if (outStall !== 1'b0) begin n_fail++; $display("FAIL pass_stall got=%b exp=0", outStall); end
    tick;
    n_tests++; if (outALUResult !== 32'h1234 || outWB !== 2'b10 || outRegF_wreg !== 5'd5) begin n_fail++; $display("FAIL pass_out got alu=%h wb=%b rd=%0d exp 1234/10/5", outALUResult, outWB, outRegF_wreg); end
    n_tests++; if (dmi.req !== 1'b0 || outStall !== 1'b0) begin n_fail++; $display("FAIL pass_noreq got req=%b stall=%b exp 0/0", dmi.req, outStall); end
  endtask

  task automatic test_load;
    int stall_cycles = 0;
    inWB = 2'b11; inMEM = 3'b010; inSize = 3'b000; inALUResult = 32'h103; inRegF_wreg = 5'd7;
    dmi.ready = 1'b0; dmi.rdata = 32'h80FFFF7F;
    #1; if (outStall === 1'b1) stall_cycles++;
    tick;
    n_tests++; if (dmi.req !== 1'b1 || dmi.we !== 1'b0 || dmi.addr !== 32'h100 || dmi.be !== 4'b1000) begin n_fail++; $display("FAIL ldb_issue got req=%b we=%b addr=%h be=%b exp 1/0/100/1000", dmi.req, dmi.we, dmi.addr, dmi.be); end
    n_tests++; if (outWB !== 2'b00) begin n_fail++; $display("FAIL ldb_bubble got wb=%b exp=00", outWB); end
    if (outStall === 1'b1) stall_cycles++;
    tick;
    if (outStall === 1'b1) stall_cycles++;
    n_tests++; if (dmi.req !== 1'b1 || dmi.addr !== 32'h100) begin n_fail++; $display("FAIL ldb_hold got req=%b addr=%h exp 1/100", dmi.req, dmi.addr); end
    tick;
    dmi.ready = 1'b1;
    #1; if (outStall === 1'b1) stall_cycles++;
    n_tests++; if (stall_cycles !== 3) begin n_fail++; $display("FAIL ldb_stall_cycles got=%0d exp=3", stall_cycles); end
    tick;
    n_tests++; if (outReadData !== 32'hFFFFFF80 || outWB !== 2'b11 || outRegF_wreg !== 5'd7 || dmi.req !== 1'b0) begin n_fail++; $display("FAIL ldb_signed got rd=%h wb=%b dst=%0d req=%b exp FFFFFF80/11/7/0", outReadData, outWB, outRegF_wreg, dmi.req); end
    // zero-extended variant with memory already ready
    inSize = 3'b100;
    #1;
    n_tests++; if (outStall !== 1'b1) begin n_fail++; $display("FAIL ldbu_stall0 got=%b exp=1", outStall); end
    tick;
    n_tests++; if (dmi.req !== 1'b1 || outStall !== 1'b0) begin n_fail++; $display("FAIL ldbu_issue got req=%b stall=%b exp 1/0", dmi.req, outStall); end
    tick;
    n_tests++; if (outReadData !== 32'h00000080 || dmi.req !== 1'b0) begin n_fail++; $display("FAIL ldbu_zext got rd=%h req=%b exp 00000080/0", outReadData, dmi.req); end
  endtask

  task automatic test_back_to_back;
    // inputs still hold the load from the previous capture
    n_tests++; if (dmi.req !== 1'b0 || outStall !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got req=%b stall=%b exp 0/1", dmi.req, outStall); end
    tick;
    n_tests++; if (dmi.req !== 1'b1) begin n_fail++; $display("FAIL b2b_issue got req=%b exp=1", dmi.req); end
    tick;
    inSize = 3'b001; inALUResult = 32'h102; dmi.rdata = 32'h80011234;
    tick;
    tick;
    n_tests++; if (outReadData !== 32'hFFFF8001) begin n_fail++; $display("FAIL ldh_signed got rd=%h exp FFFF8001", outReadData); end
    idle_inputs();
  endtask

  task automatic test_store;
    inWB = 2'b00; inMEM = 3'b001; inSize = 3'b001; inALUResult = 32'h22; inRegB = 32'hAAAA5678;
    dmi.ready = 1'b0;
    tick;
    n_tests++; if (dmi.req !== 1'b1 || dmi.we !== 1'b1 || dmi.addr !== 32'h20) begin n_fail++; $display("FAIL sth_req got req=%b we=%b addr=%h exp 1/1/20", dmi.req, dmi.we, dmi.addr); end
    n_tests++; if (dmi.wdata !== 32'h56785678 || dmi.be !== 4'b1100) begin n_fail++; $display("FAIL sth_lanes got wdata=%h be=%b exp 56785678/1100", dmi.wdata, dmi.be); end
    dmi.ready = 1'b1;
    tick;
    n_tests++; if (outReadData !== 32'h0 || dmi.req !== 1'b0) begin n_fail++; $display("FAIL sth_done got rd=%h req=%b exp 0/0", outReadData, dmi.req); end
    inSize = 3'b000; inALUResult = 32'h21; inRegB = 32'h000000AB;
    tick;
    n_tests++; if (dmi.wdata !== 32'hABABABAB || dmi.be !== 4'b0010 || dmi.addr !== 32'h20) begin n_fail++; $display("FAIL stb_lanes got wdata=%h be=%b addr=%h exp ABABABAB/0010/20", dmi.wdata, dmi.be, dmi.addr); end
    tick;
    inSize = 3'b011; inALUResult = 32'h44; inRegB = 32'hCAFEF00D;
    tick;
    n_tests++; if (dmi.wdata !== 32'hCAFEF00D || dmi.be !== 4'b1111 || dmi.addr !== 32'h44) begin n_fail++; $display("FAIL stw_lanes got wdata=%h be=%b addr=%h exp CAFEF00D/1111/44", dmi.wdata, dmi.be, dmi.addr); end
    tick;
    idle_inputs();
  endtask

  task automatic test_misaligned;
    inWB = 2'b11; inMEM = 3'b010; inSize = 3'b011; inALUResult = 32'h06; inRegF_wreg = 5'd3;
    #1;
    n_tests++; if (outStall !== 1'b0) begin n_fail++; $display("FAIL mis_stall got=%b exp=0", outStall); end
    tick;
    n_tests++; if (dmi.req !== 1'b0 || outMisaligned !== 1'b1 || outWB !== 2'b00) begin n_fail++; $display("FAIL mis_pulse got req=%b mis=%b wb=%b exp 0/1/00", dmi.req, outMisaligned, outWB); end
    inMEM = 3'b000; inWB = 2'b10;
    tick;
    n_tests++; if (outMisaligned !== 1'b0 || outWB !== 2'b10) begin n_fail++; $display("FAIL mis_clear got mis=%b wb=%b exp 0/10", outMisaligned, outWB); end
    idle_inputs();
  endtask

  task automatic test_stop_debug;
    inWB = 2'b11; inMEM = 3'b010; inSize = 3'b011; inALUResult = 32'h40; inRegF_wreg = 5'd9;
    dmi.ready = 1'b0;
    tick;
    stop_debug = 1'b1; dmi.ready = 1'b1; dmi.rdata = 32'h11223344;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++; if (dmi.req !== 1'b1 || dmi.addr !== 32'h40 || outWB !== 2'b00) begin n_fail++; $display("FAIL dbg_freeze%0d got req=%b addr=%h wb=%b exp 1/40/00", i, dmi.req, dmi.addr, outWB); end
    end
    stop_debug = 1'b0;
    #1;
    n_tests++; if (outStall !== 1'b0) begin n_fail++; $display("FAIL dbg_release_stall got=%b exp=0", outStall); end
    tick;
    n_tests++; if (outReadData !== 32'h11223344 || outWB !== 2'b11 || dmi.req !== 1'b0) begin n_fail++; $display("FAIL dbg_capture got rd=%h wb=%b req=%b exp 11223344/11/0", outReadData, outWB, dmi.req); end
    idle_inputs();
  endtask

  task automatic test_reset_busy;
    inWB = 2'b00; inMEM = 3'b001; inSize = 3'b011; inALUResult = 32'h80; inRegB = 32'hDEADBEEF;
    dmi.ready = 1'b0;
    tick;
    n_tests++; if (dmi.req !== 1'b1) begin n_fail++; $display("FAIL rstb_issue got req=%b exp=1", dmi.req); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (dmi.req !== 1'b0 || dmi.wdata !== 32'h0 || dmi.be !== 4'h0 || dmi.addr !== 32'h0) begin n_fail++; $display("FAIL rstb_dm got req=%b wdata=%h be=%b addr=%h exp 0", dmi.req, dmi.wdata, dmi.be, dmi.addr); end
    n_tests++; if (outReadData !== 32'h0 || outALUResult !== 32'h0 || outRegF_wreg !== 5'd0 || outWB !== 2'b00) begin n_fail++; $display("FAIL rstb_outs got rd=%h alu=%h dst=%0d wb=%b exp 0", outReadData, outALUResult, outRegF_wreg, outWB); end
    idle_inputs();
    #1;
    n_tests++; if (outStall !== 1'b0) begin n_fail++; $display("FAIL rstb_stall got=%b exp=0", outStall); end
    #1 rst = 1'b1;
    tick;
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_load();
    test_back_to_back();
    test_store();
    test_misaligned();
    test_stop_debug();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_access.md
# memory_access

Pipeline MEM stage sitting directly downstream of the execute stage. Consumes the EX/MEM pipeline register contents (control fields, ALU result, store data, destination register), performs byte/half/word loads and stores over a request/ready data-memory port, stalls the pipeline while an access is outstanding, and drives the MEM/WB pipeline register. The MEM/WB outputs also provide the WB-side forwarding sources (`WB_rd`, `WB_regF_wr`) used by the execute stage.

## Interface
- `ADDR_W`, 32: data-memory byte-address width.
- `clk`  in  1  clock; all state updates on falling edge (`negedge clk`), matching the other pipeline stages.
- `rst`  in  1  reset, asynchronous, active-low.
- `inWB`  in  2  [1]=regF_wr, [0]=mem_to_reg; passed through.
- `inMEM`  in  3  [2]=branch (ignored here), [1]=mem_read, [0]=mem_write.
- `inSize`  in  3  [1:0]: 00 byte, 01 half, 11 word (10 treated as word); [2]=1 zero-extend loads.
- `inALUResult`  in  32  effective address / pass-through result.
- `inRegB`  in  32  store data.
- `inRegF_wreg`  in  5  destination register.
- `stop_debug`  in  1  debug freeze.
- `dm_req`  out  1  memory request (registered).
- `dm_we`  out  1  write enable, valid with `dm_req`.
- `dm_addr`  out  ADDR_W  word-aligned address (`inALUResult` with [1:0] cleared).
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_be`  out  4  byte enables.
- `dm_ready`  in  1  memory completes access (sampled while `dm_req`=1).
- `dm_rdata`  in  32  read data, valid when `dm_ready`=1.
- `outStall`  out  1  combinational; holds upstream stages.
- `outWB`  out  2  registered WB control.
- `outReadData`  out  32  registered extended load data.
- `outALUResult`  out  32  registered pass-through.
- `outRegF_wreg`  out  5  registered destination.
- `outMisaligned`  out  1  registered one-cycle error pulse.

## Operation
- `mem_op` = mem_read | mem_write (mem_read wins if both set; access treated as load).
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. Misaligned op issues no request, completes in one cycle as a bubble (`outWB`=00), `outMisaligned`=1 for that cycle.
- FSM states: IDLE, BUSY.
  - IDLE, aligned `mem_op`: register `dm_req`=1, `dm_we`=mem_write, address/data/enables; go BUSY.
  - IDLE, no `mem_op` or misaligned: stay IDLE; pipeline register captures normally.
  - BUSY, `dm_ready`=0: hold all `dm_*` stable; stay BUSY.
  - BUSY, `dm_ready`=1: drop `dm_req`; capture extended `dm_rdata` into `outReadData` (0 for stores); capture inputs into MEM/WB register; go IDLE.
- `outStall` = aligned `mem_op` & !(state==BUSY & `dm_ready`).
- While `outStall`=1, MEM/WB register loads a bubble: `outWB`=00, other outputs hold.
- Store lanes (little-endian): byte → `dm_wdata`={4{b[7:0]}}, `dm_be`=0001<<addr[1:0]; half → {2{b[15:0]}}, `dm_be`=0011 (addr[1]=0) or 1100; word → data unchanged, 1111.
- Load extraction selects lane by addr[1:0] and size, sign-extends unless inSize[2]=1.
- `stop_debug`=1: FSM, `dm_*` and MEM/WB register all freeze; an in-flight request stays asserted; `dm_ready` ignored and not consumed.

## Timing
- Reset (async, `rst`=0): state IDLE, `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0, `dm_be`=0, `outWB`=00, `outReadData`=0, `outALUResult`=0, `outRegF_wreg`=0, `outMisaligned`=0. Reset during BUSY abandons the access; `dm_req` falls immediately.
- Non-memory instruction: 1 cycle, no stall.
- Aligned access: minimum 2 cycles (edge 1 issues request, edge 2 captures if `dm_ready` already high); each low-`dm_ready` cycle adds one.
- Back-to-back accesses: IDLE is re-entered on the capture edge; next access issues on the following edge (no request on the capture edge itself).
- `outStall` deasserts in the cycle `dm_ready` is seen in BUSY, so upstream advances on the same edge the result is captured.

## Test plan
- Reset: drive `rst`=0 mid-BUSY → `dm_req` drops asynchronously, all outputs at reset values, `outStall`=0 once no mem_op.
- ALU pass-through: inWB=10, inMEM=000, inALUResult=0x1234 → next edge `outALUResult`=0x1234, `outWB`=10, `outStall` never high.
- Load byte signed, addr 0x103, `dm_rdata`=0x80FFFF7F, ready after 2 wait cycles → `outStall` high 3 cycles, bubbles emitted, then `outReadData`=0xFFFFFF80; with inSize[2]=1 → 0x00000080.
- Store half, addr 0x22, inRegB=0xAAAA5678 → `dm_we`=1, `dm_addr`=0x20, `dm_wdata`=0x56785678, `dm_be`=1100.
- Misaligned word load at addr 0x06 → no `dm_req`, `outMisaligned`=1 one cycle, `outWB`=00, no stall.
- `stop_debug` asserted in BUSY while `dm_ready`=1 for 3 cycles → state and `dm_*` frozen; after release with `dm_ready`=1, capture occurs on the next edge.
